// File: rtl/prbs_pkg.sv
// Shared types and PRBS31 constants for the pattern-path test controller.
package prbs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEED = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int unsigned PRBS_LEN    = 31;
   localparam int unsigned PRBS_TAP_HI = 30;
   localparam int unsigned PRBS_TAP_LO = 27;
   localparam int unsigned FILL_W      = 5;
   localparam logic [PRBS_LEN-1:0] PRBS_SEED = 31'h1;

   // Feedback bit for x^31 + x^28 + 1 with the register's MSB as the oldest bit.
   function automatic logic prbs_fb(input logic [PRBS_LEN-1:0] r);
      return r[PRBS_TAP_HI] ^ r[PRBS_TAP_LO];
   endfunction

endpackage

// File: rtl/prbs31_checker.sv
// Self-synchronising PRBS31 checker: fills from the received stream, then
// predicts each bit from its own history and counts mismatches (saturating).
module prbs31_checker
   import prbs_pkg::*;
#(
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic             rx_bit,
   output logic             locked,
   output logic [ERR_W-1:0] err_cnt
);

   logic [PRBS_LEN-1:0] chk_q, chk_d;
   logic [FILL_W-1:0]   fill_q, fill_d;
   logic                locked_q, locked_d;
   logic [ERR_W-1:0]    err_q, err_d;

   always_comb begin
      chk_d    = chk_q;
      fill_d   = fill_q;
      locked_d = locked_q;
      err_d    = err_q;
      if (clear) begin
         chk_d    = '0;
         fill_d   = '0;
         locked_d = 1'b0;
         err_d    = '0;
      end else if (en) begin
         chk_d = {chk_q[PRBS_LEN-2:0], rx_bit};
         if (!locked_q) begin
            fill_d = fill_q + FILL_W'(1);
            if (fill_q == FILL_W'(PRBS_LEN - 1)) begin
               locked_d = 1'b1;
            end
         end else if ((rx_bit != prbs_fb(chk_q)) && (err_q != '1)) begin
            err_d = err_q + ERR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_q    <= '0;
         fill_q   <= '0;
         locked_q <= 1'b0;
         err_q    <= '0;
      end else begin
         chk_q    <= chk_d;
         fill_q   <= fill_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   assign locked  = locked_q;
   assign err_cnt = err_q;

endmodule

// File: rtl/prbs31_test_ctrl.sv
// Burst controller: seeds and runs the PRBS31 generator for a programmed bit
// count with optional error injection, and hosts the loopback checker.
module prbs31_test_ctrl
   import prbs_pkg::*;
#(
   parameter int unsigned LEN_W = 16,
   parameter int unsigned ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [LEN_W-1:0] burst_len,
   input  logic             inject_err,
   input  logic             rx_bit,
   input  logic             rx_valid,
   output logic             tx_bit,
   output logic             tx_valid,
   output logic             busy,
   output logic             done,
   output logic             locked,
   output logic [ERR_W-1:0] err_cnt,
   output logic [1:0]       state
);

   state_e              state_q, state_d;
   logic [PRBS_LEN-1:0] lfsr_q, lfsr_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic                cont_q, cont_d;
   logic                tx_valid_q, busy_q, done_q;
   logic                in_run, chk_clear, chk_en;

   // Next-state, bit counter and generator update.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      cont_d  = cont_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               state_d = ST_SEED;
               cnt_d   = burst_len;
               cont_d  = (burst_len == '0);
            end
         end
         ST_SEED: begin
            lfsr_d  = PRBS_SEED;
            state_d = abort ? ST_IDLE : ST_RUN;
         end
         ST_RUN: begin
            lfsr_d = {lfsr_q[PRBS_LEN-2:0], prbs_fb(lfsr_q)};
            if (!cont_q) begin
               cnt_d = cnt_q - LEN_W'(1);
            end
            // abort outranks completion when both land on the same edge
            if (abort) begin
               state_d = ST_IDLE;
            end else if (!cont_q && (cnt_q == LEN_W'(1))) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         lfsr_q     <= PRBS_SEED;
         cnt_q      <= '0;
         cont_q     <= 1'b0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         cnt_q      <= cnt_d;
         cont_q     <= cont_d;
         tx_valid_q <= (state_d == ST_RUN);
         busy_q     <= (state_d != ST_IDLE);
         done_q     <= (state_d == ST_DONE);
      end
   end

   assign in_run    = (state_q == ST_RUN);
   assign chk_clear = (state_q == ST_SEED);
   assign chk_en    = in_run && rx_valid;

   prbs31_checker #(
      .ERR_W (ERR_W)
   ) u_checker (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (chk_clear),
      .en      (chk_en),
      .rx_bit  (rx_bit),
      .locked  (locked),
      .err_cnt (err_cnt)
   );

   assign tx_bit   = lfsr_q[PRBS_TAP_HI] ^ (inject_err & in_run);
   assign tx_valid = tx_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign state    = state_q;

endmodule

// File: tb/tb_prbs31_test_ctrl.sv
// Directed bench for prbs31_test_ctrl: loopback bursts, injection, abort,
// start filtering, counter saturation (ERR_W=2 instance) and async reset.
module tb_prbs31_test_ctrl;

   localparam int unsigned LEN_W  = 16;
   localparam int unsigned ERR_W  = 8;
   localparam int unsigned ERR_W2 = 2;
   localparam int unsigned NREF   = 1024;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, abort, inject_err, rx_bit, rx_valid, loop_en;
   logic [LEN_W-1:0] burst_len;
   logic             tx_bit, tx_valid, busy, done, locked;
   logic [ERR_W-1:0] err_cnt;
   logic [1:0]       state;

   logic              start2, abort2, inject2, rx_bit2, rx_valid2;
   logic [LEN_W-1:0]  burst_len2;
   logic              tx_bit2, tx_valid2, busy2, done2, locked2;
   logic [ERR_W2-1:0] err_cnt2;
   logic [1:0]        state2;

   logic ref_b [0:NREF-1];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   bad, dones, nrun;

   always #5 clk = ~clk;

   always_comb begin
      rx_bit   = loop_en ? tx_bit   : 1'b0;
      rx_valid = loop_en ? tx_valid : 1'b0;
   end

   prbs31_test_ctrl #(.LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
      .burst_len (burst_len), .inject_err (inject_err),
      .rx_bit (rx_bit), .rx_valid (rx_valid),
      .tx_bit (tx_bit), .tx_valid (tx_valid), .busy (busy), .done (done),
      .locked (locked), .err_cnt (err_cnt), .state (state)
   );

   prbs31_test_ctrl #(.LEN_W(LEN_W), .ERR_W(ERR_W2)) dut2 (
      .clk (clk), .rst_n (rst_n), .start (start2), .abort (abort2),
      .burst_len (burst_len2), .inject_err (inject2),
      .rx_bit (rx_bit2), .rx_valid (rx_valid2),
      .tx_bit (tx_bit2), .tx_valid (tx_valid2), .busy (busy2), .done (done2),
      .locked (locked2), .err_cnt (err_cnt2), .state (state2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Walk n RUN cycles from reference index base, checking each emitted bit.
   task automatic run_bits(input int base, input int n, input int inj_at, input int abort_at,
                           output int nbad, output int ndone);
      nbad  = 0;
      ndone = 0;
      for (int i = base; i < base + n; i++) begin
         inject_err = (i == inj_at);
         abort      = (i == abort_at);
         #1;
         if (tx_valid !== 1'b1 || tx_bit !== (ref_b[i] ^ (i == inj_at))) nbad++;
         if (done === 1'b1) ndone++;
         tick();
      end
      inject_err = 1'b0;
      abort      = 1'b0;
   endtask

   initial begin
      // Reference stream from seed 1: 30 zeros, a one, then b[n]=b[n-31]^b[n-28].
      for (int i = 0; i < 31; i++) ref_b[i] = (i == 30);
      for (int i = 31; i < NREF; i++) ref_b[i] = ref_b[i-31] ^ ref_b[i-28];

      rst_n = 1'b0; start = 1'b0; abort = 1'b0; inject_err = 1'b0; loop_en = 1'b0;
      burst_len = '0;
      start2 = 1'b0; abort2 = 1'b0; inject2 = 1'b0; rx_bit2 = 1'b1; rx_valid2 = 1'b1;
      burst_len2 = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (10) tick();

      check("rst_state",    32'(state),    32'd0);
      check("rst_tx_bit",   32'(tx_bit),   32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_done",     32'(done),     32'd0);
      check("rst_locked",   32'(locked),   32'd0);
      check("rst_err_cnt",  32'(err_cnt),  32'd0);
      check("rst_err_cnt2", 32'(err_cnt2), 32'd0);

      // 100-bit loopback burst.
      loop_en = 1'b1;
      burst_len = 16'd100;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("b1_seed_state",    32'(state),    32'd1);
      check("b1_seed_busy",     32'(busy),     32'd1);
      check("b1_seed_tx_valid", 32'(tx_valid), 32'd0);
      tick();
      run_bits(0, 30, -1, -1, bad, dones);
      check("b1_prefix_bits", 32'(bad), 32'd0);
      check("b1_unlocked_30", 32'(locked), 32'd0);
      check("b1_bit31_one",   32'(tx_bit), 32'd1);
      run_bits(30, 1, -1, -1, bad, dones);
      check("b1_bit31_ok",   32'(bad),    32'd0);
      check("b1_locked_31",  32'(locked), 32'd1);
      run_bits(31, 69, -1, -1, bad, dones);
      check("b1_tail_bits",   32'(bad),      32'd0);
      check("b1_no_early_dn", 32'(dones),    32'd0);
      check("b1_done_state",  32'(state),    32'd3);
      check("b1_done_pulse",  32'(done),     32'd1);
      check("b1_done_txv",    32'(tx_valid), 32'd0);
      check("b1_err_cnt",     32'(err_cnt),  32'd0);
      check("b1_locked_done", 32'(locked),   32'd1);
      tick();
      check("b1_idle_state",  32'(state),  32'd0);
      check("b1_done_single", 32'(done),   32'd0);
      check("b1_idle_busy",   32'(busy),   32'd0);
      check("b1_idle_locked", 32'(locked), 32'd1);

      // Same burst with one injected error at RUN bit 50.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("b2_cleared_lock", 32'(locked), 32'd0);
      run_bits(0, 100, 49, -1, bad, dones);
      check("b2_bits",       32'(bad),     32'd0);
      check("b2_done_state", 32'(state),   32'd3);
      check("b2_err_cnt",    32'(err_cnt), 32'd3);
      check("b2_locked",     32'(locked),  32'd1);
      tick();
      check("b2_err_hold", 32'(err_cnt), 32'd3);

      // Continuous run, aborted after 1000 bits.
      burst_len = 16'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("c_err_cleared", 32'(err_cnt), 32'd0);
      run_bits(0, 1000, -1, 999, bad, dones);
      check("c_bits",       32'(bad),      32'd0);
      check("c_no_done",    32'(dones),    32'd0);
      check("c_abort_busy", 32'(busy),     32'd0);
      check("c_abort_txv",  32'(tx_valid), 32'd0);
      check("c_abort_st",   32'(state),    32'd0);
      check("c_abort_done", 32'(done),     32'd0);
      check("c_frozen_0",   32'(tx_bit),   32'(ref_b[1000]));
      check("c_err_cnt",    32'(err_cnt),  32'd0);
      dones = 0;
      repeat (5) begin
         tick();
         if (done === 1'b1) dones++;
      end
      check("c_frozen_5",   32'(tx_bit), 32'(ref_b[1000]));
      check("c_no_done_ab", 32'(dones),  32'd0);

      // Start+abort together in IDLE, then a start pulse during RUN.
      loop_en = 1'b0;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("sa_state", 32'(state), 32'd0);
      check("sa_busy",  32'(busy),  32'd0);
      burst_len = 16'd40;
      start = 1'b1;
      tick();
      start = 1'b0;
      nrun = 0;
      dones = 0;
      for (int i = 0; i < 60; i++) begin
         if (i == 5) begin start = 1'b1; burst_len = 16'd7; end
         if (i == 6) start = 1'b0;
         tick();
         if (tx_valid === 1'b1) nrun++;
         if (done === 1'b1) dones++;
      end
      check("ig_run_len", 32'(nrun),  32'd40);
      check("ig_dones",   32'(dones), 32'd1);
      check("ig_idle",    32'(state), 32'd0);

      // ERR_W=2 instance: all-ones input saturates the counter; restart clears it.
      burst_len2 = 16'd200;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      repeat (205) tick();
      check("sat_state",  32'(state2),   32'd0);
      check("sat_locked", 32'(locked2),  32'd1);
      check("sat_err",    32'(err_cnt2), 32'd3);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      check("sat_seed_state", 32'(state2), 32'd1);
      tick();
      check("sat_cleared", 32'(err_cnt2), 32'd0);
      check("sat_unlock",  32'(locked2),  32'd0);
      abort2 = 1'b1;
      tick();
      abort2 = 1'b0;
      check("sat_abort_busy", 32'(busy2), 32'd0);

      // Asynchronous reset in the middle of a run.
      loop_en = 1'b1;
      burst_len = 16'd100;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      run_bits(0, 40, -1, -1, bad, dones);
      check("r_pre_locked", 32'(locked), 32'd1);
      rst_n = 1'b0;
      #1;
      check("r_state",  32'(state),    32'd0);
      check("r_txv",    32'(tx_valid), 32'd0);
      check("r_locked", 32'(locked),   32'd0);
      check("r_busy",   32'(busy),     32'd0);
      check("r_done",   32'(done),     32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      run_bits(0, 30, -1, -1, bad, dones);
      check("r_prefix",   32'(bad),    32'd0);
      check("r_first_one", 32'(tx_bit), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("r_abort_idle", 32'(state), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
